// File: rtl/alsu_cmd_loader.sv
// alsu_cmd_loader
// ---------------
// Upstream command loader for the ALSU. A serial command frame arrives on
// ss_n/mosi and is sampled on the system clock. Each frame is assembled into
// a 16-bit command word. The word is decoded onto the ALSU operand and
// control fields and held there until the next good frame. Frames that are
// short, long, or fail parity are discarded, and the last good command stays
// on the outputs.
//
// Handshake: this block has no backpressure. ss_n low frames a transfer.
// mosi is sampled MSB first on every rising clk edge while ss_n is low.
// cmd_valid is a one-cycle strobe, high in the cycle where the field
// outputs first show a new command. frame_err is a one-cycle strobe that
// marks a discarded frame. The two strobes are never high together.
//
// Parameters:
//   PARITY_EN  0: 16-bit frame. 1: 17-bit frame, i.e. 16 data bits
//              followed by a trailing even-parity bit.
//
// Ports:
//   clk, rst      system clock (rising edge); synchronous active-high reset
//   ss_n, mosi    frame select (active low) and serial data, MSB first
//   opcode..direction  decoded command fields, cmd[15:0]
//   cmd_valid     one-cycle pulse, new command applied
//   frame_err     one-cycle pulse, frame discarded
//   busy          high from the first captured bit until ss_n rises
//   fsm_state     current FSM state, for debug and checkers
module alsu_cmd_loader #(
    parameter int PARITY_EN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_n,
    input  logic       mosi,
    output logic [2:0] opcode,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic       cin,
    output logic       serial_in,
    output logic       red_op_A,
    output logic       red_op_B,
    output logic       bypass_A,
    output logic       bypass_B,
    output logic       direction,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] fsm_state
);

    localparam int N = 16 + PARITY_EN;

    typedef enum logic [2:0] {
        SYNC     = 3'd0,
        IDLE     = 3'd1,
        SHIFT    = 3'd2,
        APPLY    = 3'd3,
        WAIT_END = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] shreg;
    logic [4:0]  cnt;
    logic [15:0] cmd;
    logic        extra_seen;

    // The frame as it will look once the bit on mosi is captured. At the
    // edge that captures bit N, this holds the whole frame, parity included.
    logic [16:0] frame_next;
    logic [15:0] word_next;
    logic        parity_ok;

    assign frame_next = {shreg, mosi};
    assign word_next  = (PARITY_EN != 0) ? frame_next[16:1] : frame_next[15:0];
    assign parity_ok  = (PARITY_EN == 0) || (^frame_next == 1'b0);

    assign opcode    = cmd[15:13];
    assign A         = cmd[12:10];
    assign B         = cmd[9:7];
    assign cin       = cmd[6];
    assign serial_in = cmd[5];
    assign red_op_A  = cmd[4];
    assign red_op_B  = cmd[3];
    assign bypass_A  = cmd[2];
    assign bypass_B  = cmd[1];
    assign direction = cmd[0];
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            shreg      <= '0;
            cnt        <= '0;
            cmd        <= '0;
            cmd_valid  <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            extra_seen <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                // Require ss_n high first, so a frame cut by reset is never
                // picked up mid-stream.
                SYNC: begin
                    if (ss_n) state <= IDLE;
                end
                IDLE: begin
                    if (!ss_n) begin
                        shreg <= {15'b0, mosi};
                        cnt   <= 5'd1;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!ss_n) begin
                        shreg <= frame_next[15:0];
                        cnt   <= cnt + 5'd1;
                        // Decide at the edge that captures bit N. The load
                        // and the strobe then become visible in the APPLY
                        // cycle, one cycle after that edge.
                        if (cnt == 5'(N - 1)) begin
                            state <= APPLY;
                            if (parity_ok) begin
                                cmd       <= word_next;
                                cmd_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end else begin
                        // Short frame: throw the partial word away.
                        shreg     <= '0;
                        cnt       <= '0;
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                // One cycle that ignores ss_n. busy stays high through it so
                // that busy covers the whole frame without a gap.
                APPLY: begin
                    extra_seen <= 1'b0;
                    state      <= WAIT_END;
                end
                WAIT_END: begin
                    if (ss_n) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!extra_seen) begin
                        // Long frame: flag it once. The command is already
                        // applied and stays applied.
                        frame_err  <= 1'b1;
                        extra_seen <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_cmd_loader.sv
module tb_alsu_cmd_loader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic ss_n;
    logic mosi;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // dut0: PARITY_EN=0, dut1: PARITY_EN=1, same stimulus to both
    wire [15:0] f0, f1;
    wire        cv0, fe0, busy0, cv1, fe1, busy1;
    wire [2:0]  st0, st1;

    alsu_cmd_loader #(.PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi),
        .opcode(f0[15:13]), .A(f0[12:10]), .B(f0[9:7]), .cin(f0[6]),
        .serial_in(f0[5]), .red_op_A(f0[4]), .red_op_B(f0[3]),
        .bypass_A(f0[2]), .bypass_B(f0[1]), .direction(f0[0]),
        .cmd_valid(cv0), .frame_err(fe0), .busy(busy0), .fsm_state(st0)
    );

    alsu_cmd_loader #(.PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi),
        .opcode(f1[15:13]), .A(f1[12:10]), .B(f1[9:7]), .cin(f1[6]),
        .serial_in(f1[5]), .red_op_A(f1[4]), .red_op_B(f1[3]),
        .bypass_A(f1[2]), .bypass_B(f1[1]), .direction(f1[0]),
        .cmd_valid(cv1), .frame_err(fe1), .busy(busy1), .fsm_state(st1)
    );

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;

    // ---------------- pulse monitor ----------------
    int cv0_n = 0, fe0_n = 0, cv1_n = 0, fe1_n = 0, both_n = 0;
    int cv0_last = 0, cv0_prev = 0;

    always @(negedge clk) begin
        if (cv0 === 1'b1) begin
            cv0_n++;
            cv0_prev = cv0_last;
            cv0_last = cycle;
        end
        if (fe0 === 1'b1) fe0_n++;
        if (cv1 === 1'b1) cv1_n++;
        if (fe1 === 1'b1) fe1_n++;
        if ((cv0 && fe0) || (cv1 && fe1)) both_n++;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift the low n bits of 'bits' MSB first, with ss_n held low. The task
    // returns 1 time unit after the edge that captured the last bit.
    task automatic shift_bits(input logic [19:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ss_n = 1'b0;
            mosi = bits[i];
            tick();
        end
    endtask

    // Hold ss_n low through the APPLY cycle, then give one ss_n-high cycle.
    task automatic end_frame();
        ss_n = 1'b0;
        mosi = 1'b0;
        tick();
        ss_n = 1'b1;
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] word;
        logic [2:0]  op;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [6:0]  low;   // cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction
    } vec_t;

    vec_t vecs[7];

    int cvb, feb, busy_low;

    initial begin
        vecs[0] = '{16'hA5C3, 3'b101, 3'b001, 3'b011, 7'b1000011};
        vecs[1] = '{16'h1234, 3'b000, 3'b100, 3'b100, 7'b0110100};
        vecs[2] = '{16'h8001, 3'b100, 3'b000, 3'b000, 7'b0000001};
        vecs[3] = '{16'h2000, 3'b001, 3'b000, 3'b000, 7'b0000000};
        vecs[4] = '{16'hFFFF, 3'b111, 3'b111, 3'b111, 7'b1111111};
        vecs[5] = '{16'h5A3C, 3'b010, 3'b110, 3'b100, 7'b0111100};
        vecs[6] = '{16'h0000, 3'b000, 3'b000, 3'b000, 7'b0000000};

        // ---- reset ----
        rst  = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        tick();
        tick();
        chk("reset fields0", 32'(f0), 32'h0);
        chk("reset fields1", 32'(f1), 32'h0);
        chk("reset strobes0", {29'b0, cv0, fe0, busy0}, 32'h0);
        chk("reset state0", 32'(st0), 32'(S_SYNC));
        rst = 1'b0;
        tick();
        chk("sync->idle state0", 32'(st0), 32'(S_IDLE));

        // ---- first frame A5C3 with busy tracking ----
        cvb = cv0_n;
        busy_low = 0;
        for (int i = 15; i >= 0; i--) begin
            ss_n = 1'b0;
            mosi = vecs[0].word[i];
            tick();
            if (busy0 !== 1'b1) busy_low++;
        end
        chk("a5c3 cmd_valid", 32'(cv0), 32'h1);
        chk("a5c3 fields", 32'(f0), {16'b0, 3'b101, 3'b001, 3'b011, 7'b1000011});
        chk("a5c3 busy during bits", busy_low, 0);
        ss_n = 1'b0;
        tick();
        chk("a5c3 busy in wait_end", 32'(busy0), 32'h1);
        chk("a5c3 cmd_valid one cycle", 32'(cv0), 32'h0);
        ss_n = 1'b1;
        tick();
        chk("a5c3 busy after ss_n", 32'(busy0), 32'h0);
        chk("a5c3 cmd_valid count", cv0_n - cvb, 1);

        // ---- table-driven good frames ----
        for (int v = 0; v < 7; v++) begin
            cvb = cv0_n;
            feb = fe0_n;
            shift_bits(20'(vecs[v].word), 16);
            chk($sformatf("vec%0d cmd_valid", v), 32'(cv0), 32'h1);
            chk($sformatf("vec%0d fields", v), 32'(f0),
                {16'b0, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].low});
            end_frame();
            chk($sformatf("vec%0d pulses", v), (cv0_n - cvb) * 16 + (fe0_n - feb), 16);
        end

        // ---- short frame after good A5C3 ----
        shift_bits(20'(16'hA5C3), 16);
        end_frame();
        cvb = cv0_n;
        feb = fe0_n;
        shift_bits(20'h0015A, 9);
        ss_n = 1'b1;
        tick();
        tick();
        chk("short frame_err count", fe0_n - feb, 1);
        chk("short cmd_valid count", cv0_n - cvb, 0);
        chk("short fields hold", 32'(f0), {16'b0, 3'b101, 3'b001, 3'b011, 7'b1000011});

        // ---- long frame: FFFF then four zeros ----
        cvb = cv0_n;
        feb = fe0_n;
        shift_bits({16'hFFFF, 4'h0}, 20);
        chk("long cmd_valid count", cv0_n - cvb, 1);
        chk("long frame_err count", fe0_n - feb, 1);
        chk("long fields", 32'(f0), 32'h0000FFFF);
        ss_n = 1'b1;
        tick();
        chk("long state idle", 32'(st0), 32'(S_IDLE));

        // ---- parity (dut1) ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        cvb = cv1_n;
        feb = fe1_n;
        shift_bits({3'b0, 16'hA5C3, 1'b0}, 17);
        chk("par good cmd_valid", 32'(cv1), 32'h1);
        end_frame();
        chk("par good fields", 32'(f1), {16'b0, 3'b101, 3'b001, 3'b011, 7'b1000011});
        shift_bits({3'b0, 16'h0001, 1'b0}, 17);
        chk("par bad frame_err", 32'(fe1), 32'h1);
        chk("par bad no cmd_valid", 32'(cv1), 32'h0);
        end_frame();
        chk("par bad fields hold", 32'(f1), {16'b0, 3'b101, 3'b001, 3'b011, 7'b1000011});
        chk("par pulse counts", (cv1_n - cvb) * 16 + (fe1_n - feb), 17);
        shift_bits({3'b0, 16'h0001, 1'b1}, 17);
        end_frame();
        chk("par odd-word fields", 32'(f1), 32'h00000001);

        // ---- reset in the middle of a frame ----
        cvb = cv0_n;
        feb = fe0_n;
        shift_bits(20'h0007F, 7);
        ss_n = 1'b0;
        mosi = 1'b1;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst fields", 32'(f0), 32'h0);
        chk("midrst state", 32'(st0), 32'(S_SYNC));
        shift_bits(20'h000FF, 8);
        chk("midrst still sync", 32'(st0), 32'(S_SYNC));
        chk("midrst fields hold zero", 32'(f0), 32'h0);
        chk("midrst no pulses", (cv0_n - cvb) * 16 + (fe0_n - feb), 0);
        ss_n = 1'b1;
        tick();
        shift_bits(20'(16'h2000), 16);
        end_frame();
        chk("midrst next frame", 32'(f0), {16'b0, 3'b001, 3'b000, 3'b000, 7'b0});

        // ---- back-to-back frames ----
        cvb = cv0_n;
        shift_bits(20'(16'h1234), 16);
        end_frame();
        shift_bits(20'(16'h8001), 16);
        end_frame();
        chk("b2b cmd_valid count", cv0_n - cvb, 2);
        chk("b2b spacing", cv0_last - cv0_prev, 18);
        chk("b2b final fields", 32'(f0), {16'b0, 3'b100, 3'b000, 3'b000, 7'b0000001});

        chk("cmd_valid with frame_err", both_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
